// File: rtl/proc_host_pkg.sv
// Shared types for the processor host sequencer: FSM states and pin bit positions.
// The HI state exists only when HOST_SAYHI_EN is defined.
package proc_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_READ,
        ST_DRAIN
`ifdef HOST_SAYHI_EN
        , ST_HI
`endif
    } state_t;

    localparam int READOUT_BIT = 0;
    localparam int SAYHI_BIT   = 1;
    localparam int LOAD_BIT    = 2;

    // Index width for an n-entry buffer, never zero.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/proc_host_rdbuf.sv
// Result capture buffer: written by slot index during readout, then drained
// slot 0 first onto a valid/ready stream whose data/valid are registered.
module proc_host_rdbuf import proc_host_pkg::*; #(
    parameter int READ_BYTES = 4,
    parameter int IW         = idx_w(READ_BYTES),
    parameter int BW         = $clog2(READ_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_data,
    input  logic          i_start,
    input  logic          i_single,
    input  logic          i_ready,
    output logic [7:0]    o_data,
    output logic          o_valid,
    output logic          o_done
);

    localparam int DEPTH = 1 << IW;

    logic [7:0]    r_buf [DEPTH];
    logic [IW-1:0] r_rd_idx;
    logic [BW-1:0] r_left;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          w_hs;
    logic [7:0]    w_slot0;

    assign w_hs    = r_valid & i_ready;
    assign o_done  = w_hs && (r_left == BW'(1));
    assign o_data  = r_data;
    assign o_valid = r_valid;

    // Slot 0 may be written on the same edge the drain starts (single-byte reads).
    assign w_slot0 = (i_wr_en && (i_wr_idx == '0)) ? i_wr_data : r_buf[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_rd_idx <= '0;
            r_left   <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_wr_en) r_buf[i_wr_idx] <= i_wr_data;
            if (i_start) begin
                r_valid  <= 1'b1;
                r_data   <= w_slot0;
                r_rd_idx <= IW'(1);
                r_left   <= i_single ? BW'(1) : BW'(READ_BYTES);
            end else if (w_hs) begin
                if (r_left == BW'(1)) begin
                    r_valid <= 1'b0;
                end else begin
                    r_data   <= r_buf[r_rd_idx];
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
                r_left <= r_left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_host_driver.sv
// Host-side sequencer for the processor pins: load program, run, read out, drain.
// Optional sayhi path (HI state, proc_uio[1]) enabled by HOST_SAYHI_EN.
module proc_host_driver import proc_host_pkg::*; #(
    parameter int PROG_BYTES = 16,
    parameter int RUN_CYCLES = 64,
    parameter int READ_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    output logic       busy,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] proc_ui,
    output logic [7:0] proc_uio,
    input  logic [7:0] proc_uo,
    input  logic       hi_req
);

    localparam int PW = $clog2(PROG_BYTES + 1);
    localparam int RW = $clog2(RUN_CYCLES + 1);
    localparam int BW = $clog2(READ_BYTES + 1);
    localparam int IW = idx_w(READ_BYTES);

    state_t        r_state, w_next;
    logic [PW-1:0] r_prog_cnt;
    logic [RW-1:0] r_run_cnt;
    logic [BW-1:0] r_rd_cnt;
    logic [7:0]    r_ui;
    logic          r_load;
    logic          r_busy;
    logic          r_cap_vld;
    logic [IW-1:0] r_cap_idx;
    logic          w_xfer;
    logic          w_rd_phase;
    logic [BW-1:0] w_rd_lim;
    logic          w_strobe;
    logic          w_drain_done;
    logic          w_single;
    logic [7:0]    w_uio;

    assign s_ready  = (r_state == ST_LOAD) && ena;
    assign w_xfer   = s_valid && s_ready;
    assign busy     = r_busy;
    assign proc_ui  = r_ui;
    assign proc_uio = w_uio;

`ifdef HOST_SAYHI_EN
    assign w_single = (r_state == ST_HI);
`else
    logic w_unused_hi;
    assign w_unused_hi = hi_req;
    assign w_single    = 1'b0;
`endif

    // READ and HI share the strobe counter; HI issues a single strobe.
    always_comb begin
        w_rd_phase = (r_state == ST_READ);
        w_rd_lim   = BW'(READ_BYTES);
`ifdef HOST_SAYHI_EN
        if (r_state == ST_HI) begin
            w_rd_phase = 1'b1;
            w_rd_lim   = BW'(1);
        end
`endif
        w_strobe = w_rd_phase && ena && (r_rd_cnt < w_rd_lim);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef HOST_SAYHI_EN
                if (hi_req)     w_next = ST_HI;
                else if (start) w_next = ST_LOAD;
`else
                if (start)      w_next = ST_LOAD;
`endif
            end
            ST_LOAD:  if (w_xfer && (r_prog_cnt == PW'(PROG_BYTES - 1))) w_next = ST_RUN;
            ST_RUN:   if (ena && (r_run_cnt == RW'(RUN_CYCLES - 1)))     w_next = ST_READ;
            ST_READ:  if (ena && (r_rd_cnt == w_rd_lim))                 w_next = ST_DRAIN;
`ifdef HOST_SAYHI_EN
            ST_HI:    if (ena && (r_rd_cnt == w_rd_lim))                 w_next = ST_DRAIN;
`endif
            ST_DRAIN: if (w_drain_done)                                  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_uio              = '0;
        w_uio[LOAD_BIT]    = r_load & ena;
        w_uio[READOUT_BIT] = w_strobe & (r_state == ST_READ);
`ifdef HOST_SAYHI_EN
        w_uio[SAYHI_BIT]   = w_strobe & (r_state == ST_HI);
`endif
    end

    // Captures trail their strobe by one cycle and are never suppressed by ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_ui       <= '0;
            r_load     <= 1'b0;
            r_cap_vld  <= 1'b0;
            r_cap_idx  <= '0;
            r_prog_cnt <= '0;
            r_run_cnt  <= '0;
            r_rd_cnt   <= '0;
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != ST_IDLE);
            r_load    <= w_xfer;
            r_cap_vld <= w_strobe;
            r_cap_idx <= r_rd_cnt[IW-1:0];
            if (w_xfer) r_ui <= s_data;
            if (w_next != r_state) begin
                r_prog_cnt <= '0;
                r_run_cnt  <= '0;
                r_rd_cnt   <= '0;
            end else begin
                if (w_xfer)                     r_prog_cnt <= r_prog_cnt + 1'b1;
                if ((r_state == ST_RUN) && ena) r_run_cnt  <= r_run_cnt + 1'b1;
                if (w_strobe)                   r_rd_cnt   <= r_rd_cnt + 1'b1;
            end
        end
    end

    proc_host_rdbuf #(
        .READ_BYTES (READ_BYTES)
    ) u_rdbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (r_cap_vld),
        .i_wr_idx  (r_cap_idx),
        .i_wr_data (proc_uo),
        .i_start   (w_rd_phase && (w_next == ST_DRAIN)),
        .i_single  (w_single),
        .i_ready   (m_ready),
        .o_data    (m_data),
        .o_valid   (m_valid),
        .o_done    (w_drain_done)
    );

endmodule

// File: tb/tb_proc_host_driver.sv
// Bench for proc_host_driver: processor pin model, result scoreboard, timing monitors.
// Covers load, run timing, readout/drain, stalls, ena pause, reset abort, sayhi.
module tb_proc_host_driver;

    localparam int PROG_BYTES = 16;
    localparam int RUN_CYCLES = 64;
    localparam int READ_BYTES = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       busy;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] proc_ui;
    logic [7:0] proc_uio;
    logic [7:0] proc_uo = 8'h00;
    logic       hi_req;

    proc_host_driver #(
        .PROG_BYTES (PROG_BYTES),
        .RUN_CYCLES (RUN_CYCLES),
        .READ_BYTES (READ_BYTES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .busy     (busy),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .proc_ui  (proc_ui),
        .proc_uio (proc_uio),
        .proc_uo  (proc_uo),
        .hi_req   (hi_req)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- processor pin model ----------------
    logic [7:0] mdl_q[$];
    logic       mdl_rd = 1'b0;
    logic       mdl_hi = 1'b0;

    always @(negedge clk) begin
        mdl_rd = proc_uio[0];
        mdl_hi = proc_uio[1];
    end

    // Byte k appears in the cycle after strobe k; junk otherwise exposes mistimed captures.
    always @(posedge clk) begin
        #1;
        if (mdl_rd || mdl_hi) proc_uo = (mdl_q.size() > 0) ? mdl_q.pop_front() : 8'h00;
        else                  proc_uo = 8'($urandom_range(0, 255));
    end

    int rdy_toggle = 0;
    always @(posedge clk) begin
        #1;
        m_ready = (rdy_toggle != 0) ? (cyc % 3 == 0) : 1'b1;
    end

    // ---------------- scoreboard / monitors ----------------
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;
    logic       prev_xfer  = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    int         last_xfer_cyc = 0;
    int         rd0_cyc    = 0;
    bit         rd_seen    = 1'b0;
    bit         mv_seen    = 1'b0;
    bit         chk_timing = 1'b0;
    bit         stall_pend = 1'b0;
    logic [7:0] stall_data = 8'h00;
    int         hi_cnt     = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_xfer  = 1'b0;
            stall_pend = 1'b0;
        end else begin
            check("load_pulse", proc_uio[2], prev_xfer);
            if (prev_xfer) check("proc_ui", proc_ui, prev_byte);
            check("uio_upper_zero", proc_uio[7:3], 5'd0);
            if (!ena) check("readout_paused", proc_uio[0], 1'b0);
            if (proc_uio[1]) hi_cnt++;

            if (proc_uio[0] && !rd_seen) begin
                rd_seen = 1'b1;
                rd0_cyc = cyc;
                if (chk_timing) check("xfer_to_readout", cyc - last_xfer_cyc, RUN_CYCLES + 1);
            end
            if (m_valid && !mv_seen) begin
                mv_seen = 1'b1;
                if (chk_timing) check("readout_to_mvalid", cyc - rd0_cyc, READ_BYTES + 1);
            end

            if (m_valid) begin
                if (stall_pend) check("stall_data", m_data, stall_data);
                if (m_ready) begin
                    if (exp_q.size() == 0) check("out_with_empty_q", m_valid, 1'b0);
                    else begin
                        mon_e = exp_q.pop_front();
                        check("m_data", m_data, mon_e);
                    end
                    stall_pend = 1'b0;
                end else begin
                    stall_pend = 1'b1;
                    stall_data = m_data;
                end
            end else if (stall_pend) begin
                check("stall_hold_valid", m_valid, 1'b1);
                stall_pend = 1'b0;
            end

            prev_xfer = s_valid && s_ready;
            prev_byte = s_data;
            if (prev_xfer) last_xfer_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outs();
        check("rst_proc_ui", proc_ui, 8'h00);
        check("rst_proc_uio", proc_uio, 8'h00);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_busy", busy, 1'b0);
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        @(negedge clk);
        check("start_to_sready", s_ready, 1'b1);
        check("busy_in_load", busy, 1'b1);
    endtask

    task automatic feed_prog(input logic [7:0] base);
        int n;
        @(posedge clk) #1;
        for (int i = 0; i < PROG_BYTES; i++) begin
            s_valid = 1'b1;
            s_data  = base + 8'(i);
            n = 0;
            while (!s_ready && n < 50) begin
                @(posedge clk) #1;
                n++;
            end
            if (!s_ready) begin
                check("timeout_sready", s_ready, 1'b1);
                break;
            end
            @(posedge clk) #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk) #1;
            n++;
        end
        if (busy) check("timeout_idle", busy, 1'b0);
    endtask

    task automatic pause_at_r1();
        int n = 0;
        while (!proc_uio[0] && n < 200) begin
            @(posedge clk) #1;
            n++;
        end
        check("pause_found_r0", proc_uio[0], 1'b1);
        @(posedge clk) #1 ena = 1'b0;
        repeat (5) @(posedge clk) #1;
        ena = 1'b1;
    endtask

    task automatic do_seq(input logic [7:0] base, input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3, input bit pause, input bit poke);
        logic [7:0] res [4];
        res = '{r0, r1, r2, r3};
        for (int i = 0; i < READ_BYTES; i++) begin
            exp_q.push_back(res[i]);
            mdl_q.push_back(res[i]);
        end
        rd_seen    = 1'b0;
        mv_seen    = 1'b0;
        chk_timing = !pause;
        pulse_start();
        feed_prog(base);
        if (poke) begin
            start = 1'b1;
            @(posedge clk) #1 start = 1'b0;
        end
        if (pause) pause_at_r1();
        wait_idle(600);
        check("busy_after_seq", busy, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    // ---------------- main ----------------
    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; hi_req = 1'b0;
        s_valid = 1'b0; s_data = 8'h00;
        #12;
        check_reset_outs();
        @(posedge clk) #1 rst_n = 1'b1;

        // s_valid outside LOAD is not accepted
        s_valid = 1'b1; s_data = 8'h77;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_sready", s_ready, 1'b0);
        end
        @(posedge clk) #1 s_valid = 1'b0;

        // basic sequence with timing checks
        do_seq(8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 1'b0);

        // downstream stalls plus a start pulse while busy
        rdy_toggle = 1;
        do_seq(8'h20, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        rdy_toggle = 0;

        // ena low for 5 cycles starting at R1
        do_seq(8'h80, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1, 1'b0);

        // reset during RUN aborts with no partial output
        rd_seen = 1'b1; mv_seen = 1'b1;
        pulse_start();
        feed_prog(8'h41);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outs();
        exp_q.delete();
        mdl_q.delete();
        @(posedge clk) #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("no_output_after_abort", m_valid, 1'b0);
        do_seq(8'h60, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1'b0);

        // sayhi request
        hi_cnt = 0;
`ifdef HOST_SAYHI_EN
        exp_q.push_back(8'h48);
        mdl_q.push_back(8'h48);
        @(posedge clk) #1 hi_req = 1'b1;
        @(posedge clk) #1 hi_req = 1'b0;
        check("hi_busy", busy, 1'b1);
        wait_idle(50);
        check("sayhi_pulses", hi_cnt, 1);
        check("hi_scoreboard_empty", exp_q.size(), 0);
`else
        @(posedge clk) #1 hi_req = 1'b1;
        @(posedge clk) #1 hi_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hi_ignored_busy", busy, 1'b0);
            check("hi_ignored_uio", proc_uio, 8'h00);
            check("hi_ignored_mvalid", m_valid, 1'b0);
        end
        check("sayhi_pulses", hi_cnt, 0);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
